sim_trap_ctrl: RTL
==================

// Module: sim_trap_ctrl
// PURPOSE
//  Simulation-only commit/trap sequencer between the NPC core's retire stage and the DPI-C host.
//  Registers each retired instruction into a one-cycle difftest step request and counts cycles and instructions.
//  On ebreak, stalls the core and drains the pipeline, then latches a0 and raises a sticky halt with a trap code.
//  A no-commit watchdog forces a timeout halt. The host polls halt_req and calls $finish.
// PARAMETERS
//  DRAIN_CYCLES  4     cycles held in DRAIN after ebreak retires, so the final register writeback lands; legal range >=1
//  TIMEOUT       1000  consecutive no-commit cycles in RUN that trigger a timeout halt; 0 disables the watchdog
//  CNT_W         64    width of cycle_count and instr_count
// PORTS
//  clk              in   1      core clock
//  rst              in   1      synchronous, active-high reset
//  commit_valid     in   1      one instruction retires this cycle
//  commit_pc        in   64     PC of the retiring instruction
//  commit_inst      in   32     encoding of the retiring instruction
//  commit_is_break  in   1      retiring instruction is ebreak; qualified by commit_valid
//  a0_value         in   64     live GPR x10 (a0)
//  core_stall       out  1      freezes the core; high in DRAIN and HALT
//  difftest_valid   out  1      one-cycle step request to the host
//  difftest_pc      out  64     registered commit_pc
//  difftest_inst    out  32     registered commit_inst
//  halt_req         out  1      sticky halt request to the host
//  halt_code        out  2      0=none, 1=good trap (a0==0), 2=bad trap (a0!=0), 3=timeout
//  exit_value       out  64     a0 latched on entry to HALT
//  cycle_count      out  CNT_W  cycles spent in RUN and DRAIN
//  instr_count      out  CNT_W  accepted commits
// BEHAVIOUR
//  Reset
//   - Every output is 0; state is RUN; drain_cnt and wdog_cnt are 0.
//   - rst mid-DRAIN or mid-HALT returns to RUN on the next edge.
//  States: RUN, DRAIN, HALT. HALT is terminal until rst.
//  Accepted commit
//   - A commit is accepted only when commit_valid=1 in RUN. Commits in DRAIN or HALT are ignored: not counted, no difftest pulse.
//   - Accepted commit at edge k: at k+1, difftest_valid=1, difftest_pc/inst hold that commit, and instr_count has incremented by 1.
//   - Without an accepted commit, difftest_valid=0 the next cycle; difftest_pc and difftest_inst hold their last values.
//  Ebreak
//   - An accepted commit with commit_is_break=1 in RUN does all of the following at the next edge:
//     - moves to DRAIN;
//     - loads drain_cnt=DRAIN_CYCLES;
//     - counts the instruction and pulses difftest_valid like any other commit.
//   - core_stall is asserted in the same cycle that the state is DRAIN.
//  DRAIN
//   - drain_cnt decrements once per cycle.
//   - A cycle spent in DRAIN with drain_cnt==1 moves to HALT at the next edge, so DRAIN lasts exactly DRAIN_CYCLES cycles.
//   - On that edge, exit_value <= a0_value and halt_code <= (a0_value==0 ? 1 : 2).
//  Watchdog (TIMEOUT!=0, RUN only)
//   - wdog_cnt clears on an accepted commit and otherwise increments.
//   - A cycle with no commit and wdog_cnt==TIMEOUT-1 moves to HALT with halt_code=3 and exit_value<=a0_value.
//   - If a commit and watchdog expiry fall in the same cycle, the commit wins: the commit is accepted and wdog_cnt clears.
//   - The watchdog is frozen in DRAIN; a drain always ends in a trap, never a timeout.
//  HALT
//   - halt_req=1 and core_stall=1.
//   - cycle_count, instr_count, halt_code and exit_value are frozen.
//  Counters
//   - cycle_count increments every cycle not in HALT and wraps modulo 2^CNT_W.
//   - instr_count also wraps modulo 2^CNT_W.
// TESTING
//  - 3 back-to-back commits (pc 0x80000000, +4, +8) -> difftest_valid high 3 cycles, one cycle late; instr_count=3.
//  - Ebreak committed at cycle 10 with a0=0, DRAIN_CYCLES=4 -> core_stall from 11; halt_req at 15; halt_code=1; exit_value=0.
//  - Ebreak with a0=0x2A; commit_valid=1 held during DRAIN -> instr_count unchanged after the ebreak; halt_code=2; exit_value=0x2A.
//  - TIMEOUT=8 with no commits after reset -> halt_req=1 at cycle 8; halt_code=3; cycle_count=8.
//  - TIMEOUT=8, commit exactly on cycle 7 -> no halt; wdog_cnt restarts and timeout moves to cycle 16.
//  - rst pulsed during DRAIN -> all outputs 0 next cycle; state RUN; a new commit is accepted normally.

Source files
------------

// File: rtl/sim_trap_ctrl.sv
// sim_trap_ctrl: simulation-only retire/trap sequencer between the core's
// retire stage and the difftest host.
//   clk, rst          : core clock, synchronous active-high reset
//   commit_*          : one retiring instruction per cycle (valid, pc, inst, is_break)
//   a0_value          : live x10, latched as the exit value on entry to HALT
//   core_stall        : freezes the core while draining or halted
//   difftest_*        : one-cycle step request carrying the accepted commit
//   halt_req/halt_code: sticky halt, 1=good trap, 2=bad trap, 3=timeout
//   exit_value        : a0 captured on entry to HALT
//   cycle_count       : cycles spent in RUN and DRAIN
//   instr_count       : accepted commits
module sim_trap_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 1000,
    parameter int unsigned CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_valid,
    input  logic [63:0]      commit_pc,
    input  logic [31:0]      commit_inst,
    input  logic             commit_is_break,
    input  logic [63:0]      a0_value,
    output logic             core_stall,
    output logic             difftest_valid,
    output logic [63:0]      difftest_pc,
    output logic [31:0]      difftest_inst,
    output logic             halt_req,
    output logic [1:0]       halt_code,
    output logic [63:0]      exit_value,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned WDOG_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned WDOG_LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] CODE_GOOD    = 2'd1;
    localparam logic [1:0] CODE_BAD     = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_nxt;
    logic [WDOG_W-1:0]   wdog_cnt, wdog_cnt_nxt;
    logic [1:0]          halt_code_nxt;
    logic [63:0]         exit_value_nxt;
    logic                accept_c;
    logic                wdog_expire_c;

    assign accept_c      = commit_valid && (state == S_RUN);
    // A commit in the expiry cycle wins, so expiry requires no commit.
    assign wdog_expire_c = (TIMEOUT != 0) && (state == S_RUN) && !commit_valid
                           && (wdog_cnt == WDOG_W'(WDOG_LIMIT));

    // Next-state and halt bookkeeping.
    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = drain_cnt;
        wdog_cnt_nxt   = wdog_cnt;
        halt_code_nxt  = halt_code;
        exit_value_nxt = exit_value;
        case (state)
            S_RUN: begin
                if (commit_valid) begin
                    wdog_cnt_nxt = '0;
                    if (commit_is_break) begin
                        state_nxt     = S_DRAIN;
                        drain_cnt_nxt = DRAIN_W'(DRAIN_CYCLES);
                    end
                end else if (wdog_expire_c) begin
                    state_nxt      = S_HALT;
                    halt_code_nxt  = CODE_TIMEOUT;
                    exit_value_nxt = a0_value;
                end else if (TIMEOUT != 0) begin
                    wdog_cnt_nxt = wdog_cnt + WDOG_W'(1);
                end
            end
            S_DRAIN: begin
                drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
                if (drain_cnt == DRAIN_W'(1)) begin
                    state_nxt      = S_HALT;
                    halt_code_nxt  = (a0_value == 64'd0) ? CODE_GOOD : CODE_BAD;
                    exit_value_nxt = a0_value;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_RUN;
            drain_cnt      <= '0;
            wdog_cnt       <= '0;
            core_stall     <= 1'b0;
            difftest_valid <= 1'b0;
            difftest_pc    <= '0;
            difftest_inst  <= '0;
            halt_req       <= 1'b0;
            halt_code      <= '0;
            exit_value     <= '0;
            cycle_count    <= '0;
            instr_count    <= '0;
        end else begin
            state          <= state_nxt;
            drain_cnt      <= drain_cnt_nxt;
            wdog_cnt       <= wdog_cnt_nxt;
            core_stall     <= (state_nxt != S_RUN);
            halt_req       <= (state_nxt == S_HALT);
            halt_code      <= halt_code_nxt;
            exit_value     <= exit_value_nxt;
            difftest_valid <= accept_c;
            if (accept_c) begin
                difftest_pc   <= commit_pc;
                difftest_inst <= commit_inst;
                instr_count   <= instr_count + CNT_W'(1);
            end
            if (state != S_HALT) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

endmodule
